// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared encodings for the early-branch control slice: opcode map, control
// states, the zero-register index and opcode classification helpers.
package branch_hazard_ctrl_pkg;

  typedef enum logic [3:0] {
    PC_INIT = 4'd0,
    ADDI    = 4'd1,
    ADDS    = 4'd2,
    BLT     = 4'd3,
    B       = 4'd4,
    CBZ     = 4'd5,
    LDUR    = 4'd6,
    LSL     = 4'd7,
    LSR     = 4'd8,
    MUL     = 4'd9,
    STUR    = 4'd10,
    SUBS    = 4'd11,
    INV     = 4'd12
  } opcode_e;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    LDSTALL = 2'd2
  } state_e;

  localparam logic [4:0] XZR = 5'd31;

  function automatic logic is_branch(input logic [3:0] op);
    return (op == B) || (op == BLT) || (op == CBZ);
  endfunction

  function automatic logic sets_flags(input logic [3:0] op);
    return (op == ADDS) || (op == SUBS);
  endfunction

endpackage

// File: rtl/branch_hazard_ctrl_flag_reg_unit.sv
// N/O condition-flag registers plus the EX-to-ID flag forwarding select.
module flag_reg_unit
  import branch_hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] opcode_ex_i,
  input  logic       alu_n_i,
  input  logic       alu_o_i,
  input  logic       update_en_i,
  output logic       flag_fwd_o,
  output logic       n_o,
  output logic       o_o
);

  logic nFlag_q, nFlag_d;
  logic oFlag_q, oFlag_d;

  assign flag_fwd_o = sets_flags(opcode_ex_i);

  // A flag-setting op in EX both forwards its flags and commits them at the edge.
  always_comb begin
    nFlag_d = nFlag_q;
    oFlag_d = oFlag_q;
    if (update_en_i && flag_fwd_o) begin
      nFlag_d = alu_n_i;
      oFlag_d = alu_o_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nFlag_q <= 1'b0;
      oFlag_q <= 1'b0;
    end else begin
      nFlag_q <= nFlag_d;
      oFlag_q <= oFlag_d;
    end
  end

  assign n_o = nFlag_q;
  assign o_o = oFlag_q;

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage control for the early-branch path: boot hold, CBZ load-use stalls,
// single branch delay slot, PC redirection and flag forwarding.
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = 2,
  parameter int LD_STALLS   = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       opcode_id,
  input  logic [3:0]       opcode_ex,
  input  logic [4:0]       rt_id,
  input  logic [4:0]       rd_ex,
  input  logic             alu_n,
  input  logic             alu_o,
  input  logic             br_taken,
  output logic             n_q,
  output logic             o_q,
  output logic             flag_fwd,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             pc_sel_br,
  output logic             in_delay_slot,
  output logic             ds_violation,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0]       BOOT_RELOAD = 4'(INIT_CYCLES - 1);
  localparam logic [1:0]       LD_RELOAD   = (LD_STALLS > 1) ? 2'(LD_STALLS - 2) : 2'd0;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [3:0]       bootCnt_q, bootCnt_d;
  logic [1:0]       ldCnt_q, ldCnt_d;
  logic             inDs_q, inDs_d;
  logic             dsViol_q, dsViol_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

  logic hz;
  logic idBranch;
  logic stalling;

  assign idBranch = is_branch(opcode_id);
  assign hz = (opcode_id == CBZ) && (opcode_ex == LDUR) &&
              (rd_ex == rt_id) && (rd_ex != XZR);

  // The first stall cycle is spent in RUN; LDSTALL covers any further ones.
  always_comb begin
    state_d     = state_q;
    bootCnt_d   = bootCnt_q;
    ldCnt_d     = ldCnt_q;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_bubble = 1'b1;
    pc_sel_br   = 1'b0;
    stalling    = 1'b0;
    case (state_q)
      BOOT: begin
        if (bootCnt_q == 4'd0) begin
          state_d = RUN;
        end else begin
          bootCnt_d = bootCnt_q - 4'd1;
        end
      end
      RUN: begin
        if (hz) begin
          stalling = 1'b1;
          if (LD_STALLS > 1) begin
            state_d = LDSTALL;
            ldCnt_d = LD_RELOAD;
          end
        end else begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          idex_bubble = 1'b0;
          pc_sel_br   = br_taken && idBranch && !inDs_q;
        end
      end
      LDSTALL: begin
        stalling = 1'b1;
        if (ldCnt_q == 2'd0) begin
          state_d = RUN;
        end else begin
          ldCnt_d = ldCnt_q - 2'd1;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Delay-slot tracking only advances when IF/ID actually accepts a new instruction.
  always_comb begin
    inDs_d     = inDs_q;
    dsViol_d   = dsViol_q;
    stallCnt_d = stallCnt_q;
    if (ifid_write) begin
      inDs_d = idBranch;
      if (inDs_q && idBranch) begin
        dsViol_d = 1'b1;
      end
    end
    if (stalling && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BOOT;
      bootCnt_q  <= BOOT_RELOAD;
      ldCnt_q    <= 2'd0;
      inDs_q     <= 1'b0;
      dsViol_q   <= 1'b0;
      stallCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bootCnt_q  <= bootCnt_d;
      ldCnt_q    <= ldCnt_d;
      inDs_q     <= inDs_d;
      dsViol_q   <= dsViol_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  flag_reg_unit u_flags (
    .clk         (clk),
    .reset_n     (reset_n),
    .opcode_ex_i (opcode_ex),
    .alu_n_i     (alu_n),
    .alu_o_i     (alu_o),
    .update_en_i (state_q != BOOT),
    .flag_fwd_o  (flag_fwd),
    .n_o         (n_q),
    .o_o         (o_q)
  );

  assign in_delay_slot = inDs_q;
  assign ds_violation  = dsViol_q;
  assign stall_cnt     = stallCnt_q;

endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
Pipeline control unit for the early-branch path in the register-decode (ID) stage. It owns the N/O condition-flag registers and selects the flag-forwarding path, so that B.LT sees flags produced by an ADDS/SUBS in EX. It detects CBZ load-use hazards and stalls the front end, enforces the single branch delay slot, and gates PC redirection. After reset it holds fetch for a fixed boot interval.

Parameters:
INIT_CYCLES, 2, cycles after reset release during which fetch is held (range 1..15).
LD_STALLS, 1, stall cycles inserted for a CBZ whose Rt is the destination of an LDUR in EX (range 1..3).
CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
opcode_id  in  4  opcode of the instruction in ID (shared opcode encoding).
opcode_ex  in  4  opcode of the instruction in EX.
rt_id  in  5  register tested by CBZ in ID.
rd_ex  in  5  destination register of the instruction in EX.
alu_n  in  1  N flag computed by the ALU in EX this cycle.
alu_o  in  1  O flag computed by the ALU in EX this cycle.
br_taken  in  1  raw taken indication from the ID-stage branch evaluator.
n_q  out  1  registered N flag.
o_q  out  1  registered O flag.
flag_fwd  out  1  1 = the branch evaluator uses alu_n/alu_o instead of n_q/o_q.
pc_write  out  1  PC register enable.
ifid_write  out  1  IF/ID register enable.
idex_bubble  out  1  force INV into ID/EX.
pc_sel_br  out  1  1 = next PC is the branch target.
in_delay_slot  out  1  the ID instruction occupies a branch delay slot.
ds_violation  out  1  sticky: a branch was found in a delay slot.
stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset (async assert) values: state BOOT, boot counter = INIT_CYCLES-1; n_q=o_q=0, in_delay_slot=0, ds_violation=0, stall_cnt=0. Combinational outputs while in reset: pc_write=0, ifid_write=0, idex_bubble=1, pc_sel_br=0.
- Release of reset is sampled on the first clk edge after reset_n rises.
- State BOOT:
  - pc_write=0, ifid_write=0, idex_bubble=1, pc_sel_br=0.
  - Decrement the counter each cycle; at 0, go to RUN.
  - Total boot hold is INIT_CYCLES cycles.
- Hazard term: hz = (opcode_id==CBZ) & (opcode_ex==LDUR) & (rd_ex==rt_id) & (rd_ex!=31).
- State RUN, hz=0:
  - pc_write=1, ifid_write=1, idex_bubble=0.
  - pc_sel_br = br_taken & is_branch(opcode_id) & ~in_delay_slot.
- State RUN, hz=1:
  - pc_write=0, ifid_write=0, idex_bubble=1, pc_sel_br=0.
  - If LD_STALLS==1, stay in RUN (EX holds INV next cycle, so hz clears). Otherwise go to LDSTALL with counter = LD_STALLS-2.
- State LDSTALL:
  - Same outputs as RUN with hz=1.
  - At counter 0, go to RUN; otherwise decrement.
  - A CBZ stalled by a load is therefore frozen for exactly LD_STALLS cycles.
- Flag forwarding:
  - flag_fwd = opcode_ex ∈ {ADDS, SUBS}. This is combinational and independent of state.
  - On a clk edge in RUN or LDSTALL with flag_fwd=1: n_q<=alu_n, o_q<=alu_o. Otherwise the flags hold.
  - The flags are not written in BOOT.
- Delay slot:
  - is_branch = opcode ∈ {B, BLT, CBZ}.
  - When ifid_write=1 and is_branch(opcode_id): in_delay_slot<=1 on the next edge. Any other ifid_write=1 edge clears it. Stall edges hold it.
  - A branch in a delay slot is never taken (pc_sel_br=0). ds_violation is set on the first clk edge where in_delay_slot & is_branch(opcode_id) & ifid_write, and stays set until reset.
- stall_cnt increments on every hz/LDSTALL stall cycle and saturates at all-ones. Boot cycles are not counted.
- Reset asserted mid-stall or mid-boot returns the block immediately to the reset values. No partial state survives.

Decomposition:
- Shared package: the opcode enum (PC_INIT=0, ADDI=1, ADDS=2, BLT=3, B=4, CBZ=5, LDUR=6, LSL=7, LSR=8, MUL=9, STUR=10, SUBS=11, INV=12), the state enum {BOOT, RUN, LDSTALL}, XZR index 31, and is_branch/sets_flags helper functions. The datapath stages import the same package.
- One natural sub-module, flag_reg_unit: the N/O registers plus flag_fwd generation.

Test Plan:
- Boot hold: deassert reset_n with INIT_CYCLES=2 -> pc_write=0, idex_bubble=1 for 2 cycles; pc_write=1 on cycle 3.
- Load-use stall: opcode_ex=LDUR, rd_ex=5; opcode_id=CBZ, rt_id=5 -> 1 stall cycle with pc_write=0 and idex_bubble=1, stall_cnt=1. Repeat with LD_STALLS=3 -> 3 stall cycles, stall_cnt=3.
- XZR and mismatch: rd_ex=31, rt_id=31, and separately rd_ex=4, rt_id=5 -> no stall in either case.
- Flag forwarding: opcode_ex=SUBS, alu_n=1, alu_o=0 -> flag_fwd=1 that cycle; next cycle n_q=1, o_q=0. A following ADDI leaves the flags unchanged.
- Delay slot: opcode_id=B with br_taken=1 -> pc_sel_br=1. Next cycle in_delay_slot=1; CBZ with br_taken=1 in that slot -> pc_sel_br=0 and ds_violation=1, which stays set.
- Reset mid-stall: assert reset_n=0 during LDSTALL -> all outputs immediately at reset values; BOOT is re-entered after release.
